// File: rtl/fpaddsub_normalize_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fpaddsub_normalize_shift_pipe
// Description : Pipelined left-normalisation shifter for the FP add/sub
//               datapath. Sits between the mantissa add/sub and the rounding
//               stage.
//
//               Stage 0 captures the mantissa and works out the shift amount.
//               The amount is either the leading-zero count of the mantissa or
//               an externally supplied value. In both cases it is clamped to
//               MAXSH = min(2^SHIFT_W-1, WIDTH-1), and it is forced to zero for
//               an all-zero mantissa.
//
//               Stages 1..SHIFT_W each apply one binary weight of that amount,
//               MSB weight first. The amount and the zero flag travel with the
//               data, so the last stage directly provides the exponent
//               adjustment and the zero indication.
//
//               A single global advance signal moves or stalls the whole
//               pipeline as a unit. Empty slots are not collapsed, so the
//               upstream ready depends only on the output register state.
//
// Ports       : clk, rst           clock, synchronous active-high reset
//               InValid / InReady  upstream handshake
//               MantIn             unnormalised mantissa
//               UseExt / ShiftIn   external shift select and amount
//               OutValid/OutReady  downstream handshake
//               MantOut            normalised mantissa
//               ShiftOut           shift actually applied
//               ZeroOut            input mantissa was all zero
//
// Revision    : 1.0  initial release
// ============================================================================
module fpaddsub_normalize_shift_pipe #(
  parameter int WIDTH   = 33,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   MantIn,
  input  logic               UseExt,
  input  logic [SHIFT_W-1:0] ShiftIn,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   MantOut,
  output logic [SHIFT_W-1:0] ShiftOut,
  output logic               ZeroOut
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Largest amount the shifter levels can express.
  localparam int C_SHW_MAX = (1 << SHIFT_W) - 1;
  // Effective clamp value for the shift amount.
  localparam int C_MAXSH   = (C_SHW_MAX < (WIDTH - 1)) ? C_SHW_MAX : (WIDTH - 1);
  // Width that is wide enough to hold a leading-zero count of 0..WIDTH.
  localparam int C_LZW     = $clog2(WIDTH + 1);
  // Common comparison width for the leading-zero count and the clamp value.
  localparam int C_CW      = (C_LZW > SHIFT_W) ? C_LZW : SHIFT_W;
  // Index of the last (output) stage.
  localparam int C_LAST    = SHIFT_W;

  localparam logic [SHIFT_W-1:0] C_MAXSH_S = SHIFT_W'(C_MAXSH);
  localparam logic [C_CW-1:0]    C_MAXSH_C = C_CW'(C_MAXSH);

  // --------------------------------------------------------------------------
  // Pipeline state: index 0 is the capture stage, index C_LAST is the output
  // --------------------------------------------------------------------------
  logic               valid_q [0:C_LAST];
  logic [WIDTH-1:0]   mant_q  [0:C_LAST];
  logic [SHIFT_W-1:0] sa_q    [0:C_LAST];
  logic               zero_q  [0:C_LAST];

  // Next-state data for each stage.
  logic [WIDTH-1:0]   mant_d  [0:C_LAST];

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_adv;

  // The output slot is free, or it is being drained this cycle. Either way,
  // every stage can move one position forward.
  assign w_adv   = ~valid_q[C_LAST] | OutReady;
  assign InReady = w_adv;

  // --------------------------------------------------------------------------
  // Stage 0: leading-zero count and shift-amount selection
  // --------------------------------------------------------------------------
  logic [C_LZW-1:0]   w_lzc;
  logic [C_CW-1:0]    w_lzc_ext;
  logic               w_zero;
  logic [SHIFT_W-1:0] w_sa_auto;
  logic [SHIFT_W-1:0] w_sa_ext;
  logic [SHIFT_W-1:0] sa_d;

  // The scan runs upward, so the highest set bit is the last one to write.
  // A zero mantissa leaves the count at WIDTH. That value is never used,
  // because a zero input forces the amount to 0.
  always_comb begin
    w_lzc = C_LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (MantIn[i]) begin
        w_lzc = C_LZW'(WIDTH - 1 - i);
      end
    end
  end

  assign w_zero    = (MantIn == '0);
  assign w_lzc_ext = C_CW'(w_lzc);

  // When WIDTH-1 exceeds what the levels can shift, a lone LSB clamps here.
  // The result is then only partially normalised, and the clamp is visible
  // on ShiftOut.
  assign w_sa_auto = (w_lzc_ext > C_MAXSH_C) ? C_MAXSH_S : w_lzc_ext[SHIFT_W-1:0];
  assign w_sa_ext  = (ShiftIn > C_MAXSH_S) ? C_MAXSH_S : ShiftIn;

  always_comb begin
    sa_d = UseExt ? w_sa_ext : w_sa_auto;
    if (w_zero) begin
      sa_d = '0;
    end
  end

  assign mant_d[0] = MantIn;

  // --------------------------------------------------------------------------
  // Stages 1..SHIFT_W: one binary shift level each, largest weight first.
  // This is a logical left shift. Zeros enter at the LSB, and bits pushed
  // past the MSB are lost.
  // --------------------------------------------------------------------------
  for (genvar k = 1; k <= C_LAST; k++) begin : g_shift
    localparam int C_BIT = SHIFT_W - k;
    localparam int C_AMT = 1 << C_BIT;

    assign mant_d[k] = sa_q[k-1][C_BIT] ? (mant_q[k-1] << C_AMT) : mant_q[k-1];
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  // Data fields load only together with a valid beat. As a result, the output
  // registers keep the last delivered result across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= C_LAST; k++) begin
        valid_q[k] <= 1'b0;
        mant_q[k]  <= '0;
        sa_q[k]    <= '0;
        zero_q[k]  <= 1'b0;
      end
    end else if (w_adv) begin
      valid_q[0] <= InValid;
      if (InValid) begin
        mant_q[0] <= mant_d[0];
        sa_q[0]   <= sa_d;
        zero_q[0] <= w_zero;
      end
      for (int k = 1; k <= C_LAST; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          mant_q[k] <= mant_d[k];
          sa_q[k]   <= sa_q[k-1];
          zero_q[k] <= zero_q[k-1];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign OutValid = valid_q[C_LAST];
  assign MantOut  = mant_q[C_LAST];
  assign ShiftOut = sa_q[C_LAST];
  assign ZeroOut  = zero_q[C_LAST];

endmodule
`default_nettype wire
